// File: rtl/reg_file_64.sv
// reg_file_64: 32 x 64-bit RISC-V integer register file with a busy-bit scoreboard.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_64 #(
    parameter  int XLEN  = 64,
    parameter  int NREG  = 32,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rs1,
    input  logic [IDX_W-1:0] rs2,
    output logic [XLEN-1:0]  read_data1,
    output logic [XLEN-1:0]  read_data2,
    input  logic             reg_write,
    input  logic [IDX_W-1:0] rd,
    input  logic [XLEN-1:0]  write_data,
    input  logic             set_busy,
    input  logic [IDX_W-1:0] busy_rd,
    output logic             stall,
    output logic [NREG-1:0]  busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_eff;
    logic            wr_en;
    logic            set_en;

    assign wr_en  = reg_write && (rd != '0);
    assign set_en = set_busy && (busy_rd != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd] = write_data;
        end
    end

    // Clear before set so a new producer issued on the retiring write keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[busy_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        read_data1 = (rs1 == '0) ? '0 : regs_q[rs1];
        read_data2 = (rs2 == '0) ? '0 : regs_q[rs2];
        busy_eff   = busy_q;
        if (wr_en) begin
            if (rd == rs1) begin
                read_data1 = write_data;
            end
            if (rd == rs2) begin
                read_data2 = write_data;
            end
            // The retiring value is already on the bypass, unless a new producer claims rd.
            busy_eff[rd] = set_en && (busy_rd == rd);
        end
    end
`else
    assign read_data1 = (rs1 == '0) ? '0 : regs_q[rs1];
    assign read_data2 = (rs2 == '0) ? '0 : regs_q[rs2];
    assign busy_eff   = busy_q;
`endif

    assign stall    = (busy_eff[rs1] && (rs1 != '0)) || (busy_eff[rs2] && (rs2 != '0));
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_64.sv
// Self-checking bench for reg_file_64: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_reg_file_64;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, busy_rd;
    logic [63:0] read_data1, read_data2, write_data;
    logic        reg_write, set_busy, stall;
    logic [31:0] busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file_64 dut (
        .clk        (clk),
        .rst        (rst),
        .rs1        (rs1),
        .rs2        (rs2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .reg_write  (reg_write),
        .rd         (rd),
        .write_data (write_data),
        .set_busy   (set_busy),
        .busy_rd    (busy_rd),
        .stall      (stall),
        .busy_vec   (busy_vec)
    );

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && rd != 5'd0 && rd == idx) return write_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic bit busy_now(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && rd != 5'd0 && rd == idx) return set_busy && (busy_rd == idx);
`endif
        return m_busy[idx];
    endfunction

    function automatic logic exp_stall();
        return busy_now(rs1) | busy_now(rs2);
    endfunction

    function automatic logic [31:0] exp_bvec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle();
        reg_write  = 1'b0;
        set_busy   = 1'b0;
        rd         = 5'd0;
        busy_rd    = 5'd0;
        write_data = 64'd0;
    endtask

    // Advance one clock; the model applies the rules using the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (reg_write && rd != 5'd0) begin
                m_regs[rd] = write_data;
                m_busy[rd] = 1'b0;
            end
            if (set_busy && busy_rd != 5'd0) m_busy[busy_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [63:0] d);
        reg_write = 1'b1; rd = r; write_data = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        idle();
        rs1 = 5'd5; rs2 = 5'd31;
        step();
        step();
        n_checks++; if (read_data1 !== 64'd0) begin n_fail++; $display("FAIL reset_rd1 got=%h exp=0", read_data1); end
        n_checks++; if (read_data2 !== 64'd0) begin n_fail++; $display("FAIL reset_rd2 got=%h exp=0", read_data2); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        do_write(5'd1, 64'h10);
        do_write(5'd2, 64'h12);
        rs1 = 5'd1; rs2 = 5'd2;
        #1;
        n_checks++; if (read_data1 !== 64'h10) begin n_fail++; $display("FAIL basic_rd1 got=%h exp=10", read_data1); end
        n_checks++; if (read_data2 !== 64'h12) begin n_fail++; $display("FAIL basic_rd2 got=%h exp=12", read_data2); end
        n_checks++; if (read_data1 + read_data2 !== 64'h22) begin n_fail++; $display("FAIL basic_sum got=%h exp=22", read_data1 + read_data2); end
    endtask

    task automatic test_x0();
        reg_write = 1'b1; rd = 5'd0; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        set_busy = 1'b1; busy_rd = 5'd0;
        step();
        idle();
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        n_checks++; if (read_data1 !== 64'd0) begin n_fail++; $display("FAIL x0_read got=%h exp=0", read_data1); end
        n_checks++; if (busy_vec[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got=%b exp=0", busy_vec[0]); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%b exp=0", stall); end
    endtask

    task automatic test_scoreboard();
        set_busy = 1'b1; busy_rd = 5'd7;
        step();
        idle();
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall_set got=%b exp=1", stall); end
        n_checks++; if (busy_vec[7] !== 1'b1) begin n_fail++; $display("FAIL sb_busy7 got=%b exp=1", busy_vec[7]); end
        do_write(5'd7, 64'h8000_0000_0000_0000);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sb_stall_clr got=%b exp=0", stall); end
        n_checks++; if (read_data1 !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL sb_rd1 got=%h exp=8000000000000000", read_data1); end
        n_checks++; if (busy_vec[7] !== 1'b0) begin n_fail++; $display("FAIL sb_busy7_clr got=%b exp=0", busy_vec[7]); end
    endtask

    task automatic test_collision();
        logic [63:0] exp_col;
`ifdef REGFILE_BYPASS_EN
        exp_col = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_col = 64'h1;
`endif
        do_write(5'd3, 64'h1);
        rs1 = 5'd3; rs2 = 5'd0;
        reg_write = 1'b1; rd = 5'd3; write_data = 64'h7FFF_FFFF_FFFF_FFFF;
        #1;
        n_checks++; if (read_data1 !== exp_col) begin n_fail++; $display("FAIL col_same_cycle got=%h exp=%h", read_data1, exp_col); end
        step();
        idle();
        #1;
        n_checks++; if (read_data1 !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL col_next_cycle got=%h exp=7fffffffffffffff", read_data1); end
        reg_write = 1'b1; rd = 5'd4; write_data = 64'hAB;
        set_busy = 1'b1; busy_rd = 5'd4;
        step();
        idle();
        rs1 = 5'd4;
        #1;
        n_checks++; if (busy_vec[4] !== 1'b1) begin n_fail++; $display("FAIL col_set_wins got=%b exp=1", busy_vec[4]); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL col_set_stall got=%b exp=1", stall); end
        n_checks++; if (read_data1 !== 64'hAB) begin n_fail++; $display("FAIL col_x4_data got=%h exp=ab", read_data1); end
    endtask

    task automatic test_async_reset();
        reg_write = 1'b1; rd = 5'd9; write_data = 64'h5;
        set_busy = 1'b1; busy_rd = 5'd10;
        step();
        idle();
        rs1 = 5'd9; rs2 = 5'd10;
        #1;
        n_checks++; if (read_data1 !== 64'h5) begin n_fail++; $display("FAIL ar_pre_rd1 got=%h exp=5", read_data1); end
        n_checks++; if (busy_vec !== exp_bvec() || busy_vec[10] !== 1'b1) begin n_fail++; $display("FAIL ar_pre_busy got=%h exp=%h", busy_vec, exp_bvec()); end
        reg_write = 1'b1; rd = 5'd11; write_data = 64'hDEAD;
        set_busy = 1'b1; busy_rd = 5'd12;
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        n_checks++; if (read_data1 !== 64'd0) begin n_fail++; $display("FAIL ar_async_rd1 got=%h exp=0", read_data1); end
        n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL ar_async_busy got=%h exp=0", busy_vec); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ar_async_stall got=%b exp=0", stall); end
        step();
        rst = 1'b0;
        idle();
        rs1 = 5'd11; rs2 = 5'd12;
        #1;
        n_checks++; if (read_data1 !== 64'd0) begin n_fail++; $display("FAIL ar_discard_wr got=%h exp=0", read_data1); end
        n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL ar_discard_busy got=%h exp=0", busy_vec); end
    endtask

    task automatic test_random();
        logic [63:0] e1, e2;
        logic        es;
        for (int i = 0; i < 400; i++) begin
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            rd        = 5'($urandom_range(0, 31));
            busy_rd   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            reg_write = 1'($urandom_range(0, 1));
            set_busy  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       write_data = 64'd0;
                1:       write_data = 64'hFFFF_FFFF_FFFF_FFFF;
                default: write_data = {$urandom, $urandom};
            endcase
            #1;
            e1 = exp_read(rs1);
            e2 = exp_read(rs2);
            es = exp_stall();
            n_checks++; if (read_data1 !== e1) begin n_fail++; $display("FAIL rnd_rd1 it=%0d rs1=%0d got=%h exp=%h", i, rs1, read_data1, e1); end
            n_checks++; if (read_data2 !== e2) begin n_fail++; $display("FAIL rnd_rd2 it=%0d rs2=%0d got=%h exp=%h", i, rs2, read_data2, e2); end
            n_checks++; if (stall !== es) begin n_fail++; $display("FAIL rnd_stall it=%0d got=%b exp=%b", i, stall, es); end
            n_checks++; if (busy_vec !== exp_bvec()) begin n_fail++; $display("FAIL rnd_busy it=%0d got=%h exp=%h", i, busy_vec, exp_bvec()); end
            step();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1 = 5'd0;
        rs2 = 5'd0;
        test_reset();
        test_basic();
        test_x0();
        test_scoreboard();
        test_collision();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
